// File: rtl/bht_pkg.sv
// Shared types and saturating-counter helper for the branch history table.
package bht_pkg;

  typedef enum logic [0:0] {
    CLEAR,
    RUN
  } bht_state_e;

  // Width-generic saturating step; callers truncate the result to their counter width.
  function automatic logic [31:0] sat_next(input logic [31:0] value, input logic dir,
                                           input int unsigned w);
    logic [31:0] max_val;
    max_val = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    if (dir) begin
      sat_next = (value >= max_val) ? max_val : value + 32'd1;
    end else begin
      sat_next = (value == 32'd0) ? 32'd0 : value - 32'd1;
    end
  endfunction

endpackage

// File: rtl/bht_sat_array.sv
// Array of saturating branch counters with a combinational, update-bypassed read port
// and a clear sweep that initialises every entry after reset or flush.
module bht_sat_array
  import bht_pkg::*;
#(
  parameter int unsigned s_index  = 3,
  parameter int unsigned width    = 2,
  parameter int unsigned num_sets = 2 ** s_index,
  parameter int unsigned init_val = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               read,
  input  logic [s_index-1:0] rindex,
  output logic [width-1:0]   dataout,
  output logic               taken,
  input  logic               update,
  input  logic [s_index-1:0] windex,
  input  logic               outcome,
  output logic               ready
);

  localparam logic [width-1:0]   InitVal = width'(init_val);
  localparam logic [s_index-1:0] LastIdx = s_index'(num_sets - 1);

  bht_state_e         state_q, state_d;
  logic [s_index-1:0] ptr_q, ptr_d;
  logic [width-1:0]   data_q [num_sets];

  logic               we;
  logic [s_index-1:0] waddr;
  logic [width-1:0]   wdata;
  logic [width-1:0]   upd_next;

  // One next-value result feeds both the array write and the read bypass.
  assign upd_next = width'(sat_next(32'(data_q[windex]), outcome, width));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we      = 1'b0;
    waddr   = windex;
    wdata   = upd_next;
    if (flush) begin
      state_d = CLEAR;
      ptr_d   = '0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          we    = 1'b1;
          waddr = ptr_q;
          wdata = InitVal;
          if (ptr_q == LastIdx) begin
            state_d = RUN;
          end else begin
            ptr_d = ptr_q + s_index'(1);
          end
        end
        RUN: begin
          we = update;
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Storage has no reset; CLEAR masks it until the sweep has written every entry.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      data_q[waddr] <= wdata;
    end
  end

  always_comb begin
    dataout = '0;
    if (read) begin
      if (state_q == CLEAR) begin
        dataout = InitVal;
      end else if (update && (rindex == windex)) begin
        dataout = upd_next;
      end else begin
        dataout = data_q[rindex];
      end
    end
  end

  assign taken = dataout[width-1];
  assign ready = (state_q == RUN);

endmodule

// File: tb/tb_bht_sat_array.sv
// Directed self-checking bench for bht_sat_array (s_index=3, width=2, init_val=1).
module tb_bht_sat_array;

  logic       clk = 1'b0;
  logic       rst, flush, read, update, outcome;
  logic [2:0] rindex, windex;
  logic [1:0] dataout;
  logic       taken, ready;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [1:0] up_exp [4] = '{2'd2, 2'd3, 2'd3, 2'd3};
  logic [1:0] dn_exp [5] = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd0};

  always #10 clk = ~clk;

  bht_sat_array #(
    .s_index (3),
    .width   (2),
    .num_sets(8),
    .init_val(1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .read   (read),
    .rindex (rindex),
    .dataout(dataout),
    .taken  (taken),
    .update (update),
    .windex (windex),
    .outcome(outcome),
    .ready  (ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller has just passed the rst/flush edge; ready must rise after exactly 8 more edges.
  task automatic sweep_check(input string tag);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check(tag, 32'(ready), (i == 8) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic read_all(input string tag, input logic [1:0] exp);
    for (int i = 0; i < 8; i++) begin
      rindex = 3'(i);
      #1;
      check(tag, 32'(dataout), 32'(exp));
      check({tag, "_taken"}, 32'(taken), 32'(exp[1]));
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; read = 1'b1; update = 1'b0; outcome = 1'b0;
    rindex = '0; windex = '0;

    // Reset sweep
    tick();
    rst = 1'b0;
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("clear_read_init", 32'(dataout), 32'd1);
    sweep_check("rst_sweep_ready");
    tick();
    read_all("sweep_read", 2'd1);

    // Saturation up then down on index 5
    rindex = 3'd5; windex = 3'd5;
    for (int i = 0; i < 4; i++) begin
      update = 1'b1; outcome = 1'b1;
      tick();
      update = 1'b0;
      #1;
      check("sat_up", 32'(dataout), 32'(up_exp[i]));
    end
    for (int i = 0; i < 5; i++) begin
      update = 1'b1; outcome = 1'b0;
      tick();
      update = 1'b0;
      #1;
      check("sat_dn", 32'(dataout), 32'(dn_exp[i]));
    end

    // Bypass on index 2 (holds 1)
    windex = 3'd2; rindex = 3'd2; update = 1'b1; outcome = 1'b1;
    #1;
    check("bypass_data", 32'(dataout), 32'd2);
    check("bypass_taken", 32'(taken), 32'd1);
    rindex = 3'd3;
    #1;
    check("bypass_other", 32'(dataout), 32'd1);
    read = 1'b0; rindex = 3'd2;
    #1;
    check("read0_bypass_data", 32'(dataout), 32'd0);
    check("read0_bypass_taken", 32'(taken), 32'd0);
    read = 1'b1;
    tick();
    update = 1'b0;
    #1;
    check("after_bypass", 32'(dataout), 32'd2);

    // Updates during CLEAR are dropped
    flush = 1'b1; update = 1'b1; windex = 3'd0; outcome = 1'b1;
    tick();
    flush = 1'b0;
    rindex = 3'd0;
    #1;
    check("flush_ready", 32'(ready), 32'd0);
    check("clear_ignores_bypass", 32'(dataout), 32'd1);
    read = 1'b0;
    #1;
    check("read0_clear", 32'(dataout), 32'd0);
    read = 1'b1;
    sweep_check("flush_sweep_ready");
    update = 1'b0;
    #1;
    check("flush_data0", 32'(dataout), 32'd1);
    rindex = 3'd2;
    #1;
    check("flush_data2", 32'(dataout), 32'd1);

    // Push index 7 to 2 so the following sweep has something to clear
    windex = 3'd7; rindex = 3'd7; update = 1'b1; outcome = 1'b1;
    tick();
    update = 1'b0;
    #1;
    check("pre_rst_data7", 32'(dataout), 32'd2);

    // Reset mid-sweep restarts the sweep
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("mid_sweep_ready", 32'(ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst2_ready", 32'(ready), 32'd0);
    sweep_check("rst2_sweep_ready");
    read_all("rst2_read", 2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
